serial_adder_ctrl: RTL and testbench

Bit-serial adder sequencer. It shares one 1-bit full-adder cell, built from two half_adder instances, across all bits of a WIDTH-bit operand pair. Operands stream through LSB-first, one bit per clock, with a start/busy/done handshake. It is the first multi-cycle arithmetic block in the library and sits between operand registers and any consumer needing an N-bit sum at minimal area.

---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/half_adder.sv | 12 +
 rtl/serial_fa_cell.sv | 32 +++
 rtl/serial_adder_ctrl.sv | 112 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder sequencer.
// The SERIAL_ADDER_SUB_EN build adds subtract support in serial_adder_ctrl.
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/half_adder.sv
// Combinational 1-bit half adder; building block of serial_fa_cell.
module half_adder (
  input  logic i_bit1,
  input  logic i_bit2,
  output logic o_sum,
  output logic o_carry
);

  assign o_sum   = i_bit1 ^ i_bit2;
  assign o_carry = i_bit1 & i_bit2;

endmodule

// File: rtl/serial_fa_cell.sv
// Combinational 1-bit full adder built from two half adders and an OR of
// their carries; shared across every bit position by serial_adder_ctrl.
module serial_fa_cell (
  input  logic i_bit1,
  input  logic i_bit2,
  input  logic i_carry,
  output logic o_sum,
  output logic o_carry
);

  logic ha0_sum;
  logic ha0_carry;
  logic ha1_carry;

  half_adder u_ha0 (
    .i_bit1  (i_bit1),
    .i_bit2  (i_bit2),
    .o_sum   (ha0_sum),
    .o_carry (ha0_carry)
  );

  half_adder u_ha1 (
    .i_bit1  (ha0_sum),
    .i_bit2  (i_carry),
    .o_sum   (o_sum),
    .o_carry (ha1_carry)
  );

  // Both half-adder carries can never be high together, so OR is exact.
  assign o_carry = ha0_carry | ha1_carry;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: operands stream LSB-first through one shared
// full-adder cell. Define SERIAL_ADDER_SUB_EN to add the i_sub (A-B) mode.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             i_sub,
`endif
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic [CNT_W-1:0] cnt;
  logic             carry_q;
  logic             b_bit;
  logic             carry_init;
  logic             cell_sum;
  logic             cell_carry;

`ifdef SERIAL_ADDER_SUB_EN
  logic sub_q;

  // Subtraction is A + ~B + 1: invert B at the cell and seed the carry.
  assign b_bit      = b_sr[0] ^ sub_q;
  assign carry_init = i_sub;
`else
  assign b_bit      = b_sr[0];
  assign carry_init = 1'b0;
`endif

  serial_fa_cell u_cell (
    .i_bit1  (a_sr[0]),
    .i_bit2  (b_bit),
    .i_carry (carry_q),
    .o_sum   (cell_sum),
    .o_carry (cell_carry)
  );

  // NOTE: every register here uses <= so all updates see pre-edge values;
  // blocking assignments would make the shift order depend on statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      r_sr    <= '0;
      cnt     <= '0;
      carry_q <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sub_q   <= 1'b0;
`endif
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_sum   <= '0;
      o_carry <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            a_sr    <= i_a;
            b_sr    <= i_b;
            cnt     <= '0;
            carry_q <= carry_init;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q   <= i_sub;
`endif
            o_busy  <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          r_sr    <= {cell_sum, r_sr[WIDTH-1:1]};
          carry_q <= cell_carry;
          if (cnt == LAST_BIT) begin
            // Publish the complete word in one step so no partial sum leaks.
            o_sum   <= {cell_sum, r_sr[WIDTH-1:1]};
            o_carry <= cell_carry;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          o_done <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed cases plus random
// operands against an arithmetic reference model.
module tb_serial_adder_ctrl;

  localparam int W = 8;
`ifdef SERIAL_ADDER_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  typedef struct {
    int           cyc;
    logic [W-1:0] sum;
    logic         carry;
  } done_t;

  logic         clk;
  logic         i_rst;
  logic         i_start;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
`ifdef SERIAL_ADDER_SUB_EN
  logic         i_sub;
`endif
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_sum;
  logic         o_carry;

  int    checks;
  int    errors;
  int    cyc;
  int    busy_cnt;
  done_t done_q[$];

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_start (i_start),
    .i_a     (i_a),
    .i_b     (i_b),
`ifdef SERIAL_ADDER_SUB_EN
    .i_sub   (i_sub),
`endif
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_sum   (o_sum),
    .o_carry (o_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observer: counts edges, busy cycles, and logs every completion.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (o_busy) busy_cnt++;
    if (o_done) done_q.push_back('{cyc: cyc, sum: o_sum, carry: o_carry});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_sub(input logic sub);
`ifdef SERIAL_ADDER_SUB_EN
    i_sub = sub;
`endif
  endtask

  // Reference: plain (W+1)-bit arithmetic; subtract is A + ~B + 1.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic sub);
    logic [W-1:0] nb;
    nb = ~b;
    if (sub && SUB_EN) return {1'b0, a} + {1'b0, nb} + (W+1)'(1);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // mode 0: quiet inputs; 1: random noise on i_start/i_a/i_b while busy;
  // 2: one i_start pulse with new operands at SHIFT cycle 3.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input int mode);
    int         n0, c0, b0, k;
    logic [W:0] exp;
    exp = model(a, b, sub);
    @(negedge clk);
    n0 = done_q.size();
    c0 = cyc;
    b0 = busy_cnt;
    i_a = a;
    i_b = b;
    set_sub(sub);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    k = 1;
    while (done_q.size() == n0 && k < 4 * W) begin
      if (mode == 1) begin
        i_start = 1'($urandom);
        i_a     = W'($urandom);
        i_b     = W'($urandom);
        set_sub(1'($urandom));
      end else if (mode == 2 && k == 3) begin
        i_start = 1'b1;
        i_a     = 8'hAA;
        i_b     = 8'h55;
      end else if (mode == 2 && k == 4) begin
        i_start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    i_start = 1'b0;
    if (done_q.size() == n0) begin
      check({tag, " done timeout"}, 0, 1);
      return;
    end
    check({tag, " latency"}, done_q[n0].cyc - c0 - 1, W);
    check({tag, " busy cycles"}, busy_cnt - b0, W);
    check({tag, " sum"}, done_q[n0].sum, exp[W-1:0]);
    check({tag, " carry"}, done_q[n0].carry, exp[W]);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rs;
    int           n0, k;

    checks   = 0;
    errors   = 0;
    cyc      = 0;
    busy_cnt = 0;
    i_rst    = 1'b1;
    i_start  = 1'b0;
    i_a      = '0;
    i_b      = '0;
    set_sub(1'b0);
    repeat (3) @(negedge clk);
    check("reset busy", o_busy, 0);
    check("reset done", o_done, 0);
    check("reset sum", o_sum, 0);
    check("reset carry", o_carry, 0);
    i_rst = 1'b0;

    do_op("3c+42", 8'h3C, 8'h42, 1'b0, 0);
    check("3c+42 abs sum", o_sum, 8'h7E);

    do_op("ff+01", 8'hFF, 8'h01, 1'b0, 0);
    n0 = done_q.size();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("ff+01 hold sum", o_sum, 8'h00);
      check("ff+01 hold carry", o_carry, 1);
    end
    check("ff+01 no extra done", done_q.size(), n0);

    n0 = done_q.size();
    do_op("10+20 ignore start", 8'h10, 8'h20, 1'b0, 2);
    repeat (12) @(negedge clk);
    check("10+20 single done", done_q.size() - n0, 1);
    check("10+20 held sum", o_sum, 8'h30);

    // Abort mid-operation: reset during SHIFT cycle 4.
    @(negedge clk);
    n0 = done_q.size();
    i_a = 8'h3C;
    i_b = 8'h42;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (3) @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    check("abort busy", o_busy, 0);
    check("abort sum", o_sum, 0);
    check("abort carry", o_carry, 0);
    repeat (20) @(negedge clk);
    check("abort no done", done_q.size(), n0);

    // Back-to-back with i_start held high.
    @(negedge clk);
    n0 = done_q.size();
    i_a = 8'h01;
    i_b = 8'h01;
    i_start = 1'b1;
    @(negedge clk);
    i_a = 8'h80;
    i_b = 8'h80;
    k = 0;
    while (done_q.size() < n0 + 2 && k < 40) begin
      @(negedge clk);
      k++;
    end
    i_start = 1'b0;
    if (done_q.size() < n0 + 2) begin
      check("held start two dones", done_q.size() - n0, 2);
    end else begin
      check("held start spacing", done_q[n0+1].cyc - done_q[n0].cyc, W + 2);
      check("held 01+01 sum", done_q[n0].sum, 8'h02);
      check("held 01+01 carry", done_q[n0].carry, 0);
      check("held 80+80 sum", done_q[n0+1].sum, 8'h00);
      check("held 80+80 carry", done_q[n0+1].carry, 1);
    end

    if (SUB_EN) begin
      do_op("05-07", 8'h05, 8'h07, 1'b1, 0);
      check("05-07 abs sum", o_sum, 8'hFE);
      do_op("07-05", 8'h07, 8'h05, 1'b1, 0);
      check("07-05 abs carry", o_carry, 1);
      do_op("07-07", 8'h07, 8'h07, 1'b1, 0);
      do_op("sub0 add", 8'h81, 8'h90, 1'b0, 0);
    end

    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = SUB_EN ? 1'($urandom) : 1'b0;
      do_op($sformatf("rand%0d", i), ra, rb, rs, (i % 2 == 1) ? 1 : 0);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
